sargantana_icache_ctrl: RTL and testbench

- Lookup/refill/flush sequencer for the Sargantana instruction cache.
- Accepts fetch lookups and drives the tag/data array read.
- Consumes the per-way hit vector from the tag checker and issues line refills to the L2 on a miss.
- Selects the victim way, writes refilled lines, and walks all sets to invalidate on a flush.

---
 rtl/sargantana_icache_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_sargantana_icache_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_icache_ctrl.sv
`timescale 1ns/1ps
// Sargantana instruction-cache lookup / refill / flush sequencer.
// Optional multi-hit detection and self-flush: define ICACHE_MULTIHIT_CHK_EN.
module sargantana_icache_ctrl #(
  parameter int ICACHE_N_WAY     = 4,
  parameter int ICACHE_IDX_WIDTH = 6
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        req_valid_i,
  input  logic [ICACHE_IDX_WIDTH-1:0] req_idx_i,
  output logic                        req_ready_o,
  input  logic                        kill_i,
  input  logic                        flush_i,
  input  logic                        tag_valid_i,
  input  logic [ICACHE_N_WAY-1:0]     cline_hit_i,
  input  logic [ICACHE_N_WAY-1:0]     way_valid_bits_i,
  output logic                        cache_rd_o,
  output logic [ICACHE_IDX_WIDTH-1:0] cache_idx_o,
  output logic [ICACHE_N_WAY-1:0]     way_we_o,
  output logic                        valid_clr_o,
  output logic                        resp_valid_o,
  output logic                        refill_req_o,
  input  logic                        refill_ack_i,
  input  logic                        refill_valid_i,
  output logic                        flush_done_o,
  output logic                        multihit_o
);

  localparam int WAY_W = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    MISS_REQ,
    MISS_WAIT,
    REFILL,
    DRAIN,
    FLUSH
  } state_e;

  state_e                      state_q, state_d;
  logic [ICACHE_IDX_WIDTH-1:0] idx_q, idx_d;
  logic [ICACHE_IDX_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic [ICACHE_N_WAY-1:0]     vbits_q, vbits_d;
  logic [WAY_W-1:0]            rr_q, rr_d;
  logic                        replay_q, replay_d;
  logic [ICACHE_N_WAY-1:0]     victim_oh;
  logic                        free_found;
  logic                        multi_hit;
  logic                        accept;

`ifdef ICACHE_MULTIHIT_CHK_EN
  logic multihit_q;
  logic mh_set;

  assign multi_hit  = |(cline_hit_i & (cline_hit_i - ICACHE_N_WAY'(1)));
  assign mh_set     = (state_q == COMPARE) && !kill_i && !replay_q && tag_valid_i && multi_hit;
  assign multihit_o = multihit_q;
`else
  assign multi_hit  = 1'b0;
  assign multihit_o = 1'b0;
`endif

  // Prefer an empty way; only a fully valid set consumes the round-robin pointer.
  always_comb begin
    victim_oh  = '0;
    free_found = 1'b0;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      if (!free_found && !vbits_q[w]) begin
        victim_oh[w] = 1'b1;
        free_found   = 1'b1;
      end
    end
    if (!free_found) begin
      victim_oh[rr_q] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    vbits_d      = vbits_q;
    rr_d         = rr_q;
    flush_cnt_d  = flush_cnt_q;
    replay_d     = 1'b0;
    accept       = 1'b0;
    req_ready_o  = 1'b0;
    cache_rd_o   = 1'b0;
    cache_idx_o  = '0;
    way_we_o     = '0;
    valid_clr_o  = 1'b0;
    resp_valid_o = 1'b0;
    refill_req_o = 1'b0;
    flush_done_o = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = rstn_i && !flush_i;
        if (flush_i) begin
          state_d = FLUSH;
        end else if (req_valid_i && rstn_i) begin
          accept = 1'b1;
        end
      end

      COMPARE: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (replay_q) begin
          // Re-read the freshly written line; the hit is reported next cycle.
          cache_rd_o  = 1'b1;
          cache_idx_o = idx_q;
        end else if (tag_valid_i) begin
          if (|cline_hit_i) begin
            if (multi_hit) begin
              state_d = FLUSH;
            end else begin
              resp_valid_o = 1'b1;
              req_ready_o  = !flush_i;
              if (flush_i) begin
                state_d = FLUSH;
              end else if (req_valid_i) begin
                accept = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end else begin
            vbits_d = way_valid_bits_i;
            state_d = MISS_REQ;
          end
        end
      end

      MISS_REQ: begin
        refill_req_o = 1'b1;
        if (refill_ack_i) begin
          if (kill_i) begin
            state_d = refill_valid_i ? IDLE : DRAIN;
          end else begin
            state_d = refill_valid_i ? REFILL : MISS_WAIT;
          end
        end else if (kill_i) begin
          state_d = IDLE;
        end
      end

      MISS_WAIT: begin
        if (kill_i) begin
          state_d = refill_valid_i ? IDLE : DRAIN;
        end else if (refill_valid_i) begin
          state_d = REFILL;
        end
      end

      DRAIN: begin
        if (refill_valid_i) begin
          state_d = IDLE;
        end
      end

      REFILL: begin
        way_we_o    = victim_oh;
        cache_idx_o = idx_q;
        if (&vbits_q) begin
          rr_d = rr_q + WAY_W'(1);
        end
        if (kill_i) begin
          state_d = IDLE;
        end else if (flush_i) begin
          state_d = FLUSH;
        end else begin
          state_d  = COMPARE;
          replay_d = 1'b1;
        end
      end

      FLUSH: begin
        valid_clr_o = 1'b1;
        cache_idx_o = flush_cnt_q;
        if (flush_cnt_q == '1) begin
          flush_done_o = 1'b1;
          flush_cnt_d  = '0;
          state_d      = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + ICACHE_IDX_WIDTH'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (accept) begin
      cache_rd_o  = 1'b1;
      cache_idx_o = req_idx_i;
      idx_d       = req_idx_i;
      state_d     = COMPARE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      flush_cnt_q <= '0;
      vbits_q     <= '0;
      rr_q        <= '0;
      replay_q    <= 1'b0;
`ifdef ICACHE_MULTIHIT_CHK_EN
      multihit_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      flush_cnt_q <= flush_cnt_d;
      vbits_q     <= vbits_d;
      rr_q        <= rr_d;
      replay_q    <= replay_d;
`ifdef ICACHE_MULTIHIT_CHK_EN
      if (mh_set) begin
        multihit_q <= 1'b1;
      end
`endif
    end
  end

  a_way_we_onehot: assert property (@(posedge clk_i) disable iff (!rstn_i)
    $onehot0(way_we_o));
  a_array_ops_exclusive: assert property (@(posedge clk_i) disable iff (!rstn_i)
    $onehot0({cache_rd_o, |way_we_o, valid_clr_o}));
  a_resp_only_compare: assert property (@(posedge clk_i) disable iff (!rstn_i)
    resp_valid_o |-> (state_q == COMPARE));

endmodule

// File: tb/tb_sargantana_icache_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for sargantana_icache_ctrl: vector table, directed
// corner-case sequences and randomized lookups against a victim-choice model.
module tb_sargantana_icache_ctrl;

  localparam int NWAY = 4;
  localparam int IDXW = 6;
  localparam int NSET = 1 << IDXW;

  logic            clk;
  logic            rstn;
  logic            reqValid;
  logic [IDXW-1:0] reqIdx;
  logic            reqReady;
  logic            kill;
  logic            flush;
  logic            tagValid;
  logic [NWAY-1:0] clineHit;
  logic [NWAY-1:0] wayValidBits;
  logic            cacheRd;
  logic [IDXW-1:0] cacheIdx;
  logic [NWAY-1:0] wayWe;
  logic            validClr;
  logic            respValid;
  logic            refillReq;
  logic            refillAck;
  logic            refillValid;
  logic            flushDone;
  logic            multihit;

  int tests    = 0;
  int failures = 0;
  int rrModel  = 0;

  typedef struct {
    logic [IDXW-1:0] idx;
    logic [NWAY-1:0] hit;
    logic [NWAY-1:0] vb;
    int              ackDly;
    int              valDly;
    logic [NWAY-1:0] expWe;
  } vec_t;

  vec_t vecs[12];

  sargantana_icache_ctrl #(
    .ICACHE_N_WAY     (NWAY),
    .ICACHE_IDX_WIDTH (IDXW)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .req_valid_i      (reqValid),
    .req_idx_i        (reqIdx),
    .req_ready_o      (reqReady),
    .kill_i           (kill),
    .flush_i          (flush),
    .tag_valid_i      (tagValid),
    .cline_hit_i      (clineHit),
    .way_valid_bits_i (wayValidBits),
    .cache_rd_o       (cacheRd),
    .cache_idx_o      (cacheIdx),
    .way_we_o         (wayWe),
    .valid_clr_o      (validClr),
    .resp_valid_o     (respValid),
    .refill_req_o     (refillReq),
    .refill_ack_i     (refillAck),
    .refill_valid_i   (refillValid),
    .flush_done_o     (flushDone),
    .multihit_o       (multihit)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequencer wedges somewhere a directed wait did not expect.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Victim rule: lowest empty way, otherwise the round-robin way.
  function automatic logic [NWAY-1:0] modelVictim(input logic [NWAY-1:0] vb);
    for (int w = 0; w < NWAY; w++) begin
      if (!vb[w]) return NWAY'(1) << w;
    end
    return NWAY'(1) << rrModel;
  endfunction

  // Array-op exclusivity and one-hot writes are checked every active cycle.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      checkOutput("inv.exclusive", 32'(int'(cacheRd) + int'(|wayWe) + int'(validClr) <= 1), 32'd1);
      checkOutput("inv.onehot", 32'($onehot0(wayWe)), 32'd1);
    end
  end

  // One full lookup from IDLE: hit, or miss -> refill -> replay -> hit. Ends back in IDLE.
  task automatic applyStimulus(input logic [IDXW-1:0] idx, input logic [NWAY-1:0] hit,
                               input logic [NWAY-1:0] vb, input int ackDly, input int valDly,
                               input logic [NWAY-1:0] expWe);
    reqValid = 1'b1;
    reqIdx   = idx;
    #1;
    checkOutput("lookup.ready", 32'(reqReady), 32'd1);
    checkOutput("lookup.rd", 32'(cacheRd), 32'd1);
    checkOutput("lookup.idx", 32'(cacheIdx), 32'(idx));
    tick();
    reqValid     = 1'b0;
    tagValid     = 1'b1;
    clineHit     = hit;
    wayValidBits = vb;
    #1;
    if (hit != '0) begin
      checkOutput("hit.resp", 32'(respValid), 32'd1);
      tick();
      tagValid = 1'b0;
      clineHit = '0;
    end else begin
      checkOutput("miss.resp", 32'(respValid), 32'd0);
      tick();
      tagValid = 1'b0;
      clineHit = '0;
      for (int k = 0; k < ackDly; k++) begin
        #1;
        checkOutput("miss.req_hold", 32'(refillReq), 32'd1);
        tick();
      end
      refillAck   = 1'b1;
      refillValid = (valDly == 0);
      #1;
      checkOutput("miss.req_ack", 32'(refillReq), 32'd1);
      tick();
      refillAck   = 1'b0;
      refillValid = 1'b0;
      for (int k = 1; k <= valDly; k++) begin
        refillValid = (k == valDly);
        #1;
        checkOutput("wait.no_we", 32'(wayWe), 32'd0);
        checkOutput("wait.no_req", 32'(refillReq), 32'd0);
        tick();
      end
      refillValid = 1'b0;
      #1;
      checkOutput("refill.we", 32'(wayWe), 32'(expWe));
      checkOutput("refill.idx", 32'(cacheIdx), 32'(idx));
      tick();
      if (&vb) rrModel = (rrModel + 1) % NWAY;
      #1;
      checkOutput("replay.rd", 32'(cacheRd), 32'd1);
      checkOutput("replay.idx", 32'(cacheIdx), 32'(idx));
      checkOutput("replay.no_resp", 32'(respValid), 32'd0);
      tick();
      tagValid = 1'b1;
      clineHit = expWe;
      #1;
      checkOutput("replay.resp", 32'(respValid), 32'd1);
      tick();
      tagValid = 1'b0;
      clineHit = '0;
    end
  endtask

  // Expects the DUT to be in its first flush cycle; walks all sets and returns to IDLE.
  task automatic runFlush();
    for (int i = 0; i < NSET; i++) begin
      kill = (i == 10);
      #1;
      checkOutput("flush.clr", 32'(validClr), 32'd1);
      checkOutput("flush.idx", 32'(cacheIdx), 32'(i));
      checkOutput("flush.done", 32'(flushDone), 32'(i == NSET - 1));
      checkOutput("flush.ready", 32'(reqReady), 32'd0);
      tick();
    end
    kill  = 1'b0;
    flush = 1'b0;
    #1;
    checkOutput("flush.end_clr", 32'(validClr), 32'd0);
    checkOutput("flush.end_ready", 32'(reqReady), 32'd1);
  endtask

  initial begin
    logic [NWAY-1:0] vbR, expR;

    // Vector table: hits, a miss into an empty way, the round-robin sequence, and more.
    vecs[0]  = '{6'd5,  4'b0100, 4'b0000, 0, 0, 4'b0000};
    vecs[1]  = '{6'd63, 4'b1000, 4'b1111, 0, 0, 4'b0000};
    vecs[2]  = '{6'd0,  4'b0001, 4'b0000, 0, 0, 4'b0000};
    vecs[3]  = '{6'd9,  4'b0000, 4'b1011, 3, 2, 4'b0100};
    vecs[4]  = '{6'd10, 4'b0000, 4'b1111, 0, 0, 4'b0001};
    vecs[5]  = '{6'd11, 4'b0000, 4'b1111, 1, 1, 4'b0010};
    vecs[6]  = '{6'd12, 4'b0000, 4'b1111, 2, 0, 4'b0100};
    vecs[7]  = '{6'd13, 4'b0000, 4'b1111, 0, 3, 4'b1000};
    vecs[8]  = '{6'd14, 4'b0000, 4'b1111, 1, 2, 4'b0001};
    vecs[9]  = '{6'd20, 4'b0000, 4'b0000, 0, 1, 4'b0001};
    vecs[10] = '{6'd21, 4'b0000, 4'b0110, 2, 2, 4'b0001};
    vecs[11] = '{6'd22, 4'b0000, 4'b1111, 0, 0, 4'b0010};

    rstn = 1'b1; reqValid = 1'b0; reqIdx = '0; kill = 1'b0; flush = 1'b0;
    tagValid = 1'b0; clineHit = '0; wayValidBits = '0; refillAck = 1'b0; refillValid = 1'b0;
    #1 rstn = 1'b0;
    #1;
    checkOutput("reset.ready", 32'(reqReady), 32'd0);
    checkOutput("reset.rd", 32'(cacheRd), 32'd0);
    checkOutput("reset.idx", 32'(cacheIdx), 32'd0);
    checkOutput("reset.we", 32'(wayWe), 32'd0);
    checkOutput("reset.clr", 32'(validClr), 32'd0);
    checkOutput("reset.resp", 32'(respValid), 32'd0);
    checkOutput("reset.refill_req", 32'(refillReq), 32'd0);
    checkOutput("reset.done", 32'(flushDone), 32'd0);
    checkOutput("reset.multihit", 32'(multihit), 32'd0);
    reqValid = 1'b1;
    #1;
    checkOutput("reset.no_accept", 32'(cacheRd), 32'd0);
    reqValid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    #1;
    checkOutput("idle.ready", 32'(reqReady), 32'd1);

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].idx, vecs[v].hit, vecs[v].vb, vecs[v].ackDly, vecs[v].valDly, vecs[v].expWe);
    end

    // Back-to-back hits: idx 5, 6, 7 give responses on three consecutive cycles.
    tick();
    reqValid = 1'b1; reqIdx = 6'd5;
    #1;
    checkOutput("b2b.rd0", 32'(cacheRd), 32'd1);
    checkOutput("b2b.idx0", 32'(cacheIdx), 32'd5);
    for (int i = 1; i <= 3; i++) begin
      tick();
      reqValid = (i < 3);
      reqIdx   = 6'(5 + i);
      tagValid = 1'b1;
      clineHit = 4'b0100;
      #1;
      checkOutput("b2b.resp", 32'(respValid), 32'd1);
      checkOutput("b2b.rd", 32'(cacheRd), 32'(i < 3));
      if (i < 3) checkOutput("b2b.idx", 32'(cacheIdx), 32'(5 + i));
    end
    tick();
    reqValid = 1'b0; tagValid = 1'b0; clineHit = '0;

    // Kill in COMPARE: no response, not ready that cycle, back in IDLE next.
    reqValid = 1'b1; reqIdx = 6'd40;
    tick();
    reqValid = 1'b0; tagValid = 1'b1; clineHit = 4'b0010; kill = 1'b1;
    #1;
    checkOutput("killcmp.resp", 32'(respValid), 32'd0);
    checkOutput("killcmp.ready", 32'(reqReady), 32'd0);
    tick();
    kill = 1'b0; tagValid = 1'b0; clineHit = '0;
    #1;
    checkOutput("killcmp.idle_ready", 32'(reqReady), 32'd1);

    // Kill in MISS_REQ before the ack: refill request drops next cycle.
    reqValid = 1'b1; reqIdx = 6'd41;
    tick();
    reqValid = 1'b0; tagValid = 1'b1; wayValidBits = 4'b1111;
    tick();
    tagValid = 1'b0; kill = 1'b1;
    #1;
    checkOutput("killreq.req", 32'(refillReq), 32'd1);
    checkOutput("killreq.ready", 32'(reqReady), 32'd0);
    tick();
    kill = 1'b0;
    #1;
    checkOutput("killreq.req_drop", 32'(refillReq), 32'd0);
    checkOutput("killreq.idle_ready", 32'(reqReady), 32'd1);

    // Kill in MISS_WAIT: the late refill beat is drained without a write.
    reqValid = 1'b1; reqIdx = 6'd42;
    tick();
    reqValid = 1'b0; tagValid = 1'b1; wayValidBits = 4'b1111;
    tick();
    tagValid = 1'b0; refillAck = 1'b1;
    tick();
    refillAck = 1'b0; kill = 1'b1;
    #1;
    checkOutput("killwait.ready", 32'(reqReady), 32'd0);
    tick();
    kill = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      refillValid = (k == 4);
      #1;
      checkOutput("drain.no_we", 32'(wayWe), 32'd0);
      checkOutput("drain.ready", 32'(reqReady), 32'd0);
      tick();
    end
    refillValid = 1'b0;
    #1;
    checkOutput("drain.idle_ready", 32'(reqReady), 32'd1);
    checkOutput("drain.idle_we", 32'(wayWe), 32'd0);

    // Kill in REFILL: the write still lands, but there is no replay.
    expR = modelVictim(4'b1111);
    reqValid = 1'b1; reqIdx = 6'd43;
    tick();
    reqValid = 1'b0; tagValid = 1'b1; wayValidBits = 4'b1111;
    tick();
    tagValid = 1'b0; refillAck = 1'b1; refillValid = 1'b1;
    tick();
    refillAck = 1'b0; refillValid = 1'b0; kill = 1'b1;
    #1;
    checkOutput("killrefill.we", 32'(wayWe), 32'(expR));
    tick();
    rrModel = (rrModel + 1) % NWAY;
    kill = 1'b0;
    #1;
    checkOutput("killrefill.no_replay", 32'(cacheRd), 32'd0);
    checkOutput("killrefill.ready", 32'(reqReady), 32'd1);

    // Flush from IDLE takes priority over a simultaneous request.
    reqValid = 1'b1; reqIdx = 6'd1; flush = 1'b1;
    #1;
    checkOutput("flushidle.ready", 32'(reqReady), 32'd0);
    checkOutput("flushidle.rd", 32'(cacheRd), 32'd0);
    tick();
    reqValid = 1'b0;
    runFlush();

    // Flush raised during a miss: refill completes, then flush without replay.
    tick();
    reqValid = 1'b1; reqIdx = 6'd33;
    tick();
    reqValid = 1'b0; tagValid = 1'b1; wayValidBits = 4'b0111;
    tick();
    tagValid = 1'b0; flush = 1'b1; refillAck = 1'b1;
    #1;
    checkOutput("flushmiss.req", 32'(refillReq), 32'd1);
    checkOutput("flushmiss.ready", 32'(reqReady), 32'd0);
    tick();
    refillAck = 1'b0; refillValid = 1'b1;
    #1;
    checkOutput("flushmiss.wait_clr", 32'(validClr), 32'd0);
    tick();
    refillValid = 1'b0;
    #1;
    checkOutput("flushmiss.we", 32'(wayWe), 32'b1000);
    checkOutput("flushmiss.idx", 32'(cacheIdx), 32'd33);
    tick();
    runFlush();

    // Multi-hit: flagged and self-flushing when the check is built in, else a plain hit.
    tick();
    reqValid = 1'b1; reqIdx = 6'd3;
    tick();
    reqValid = 1'b0; tagValid = 1'b1; clineHit = 4'b0011;
    #1;
`ifdef ICACHE_MULTIHIT_CHK_EN
    checkOutput("multihit.no_resp", 32'(respValid), 32'd0);
    tick();
    tagValid = 1'b0; clineHit = '0;
    #1;
    checkOutput("multihit.flag", 32'(multihit), 32'd1);
    runFlush();
    checkOutput("multihit.sticky", 32'(multihit), 32'd1);
`else
    checkOutput("multihit.resp", 32'(respValid), 32'd1);
    tick();
    tagValid = 1'b0; clineHit = '0;
    #1;
    checkOutput("multihit.flag", 32'(multihit), 32'd0);
`endif

    // Randomized lookups; miss victims come from the model's rule and pointer.
    for (int r = 0; r < 40; r++) begin
      tick();
      if ($urandom_range(0, 2) == 0) begin
        applyStimulus(6'($urandom_range(0, NSET - 1)), NWAY'(1) << $urandom_range(0, NWAY - 1),
                      4'($urandom_range(0, 15)), 0, 0, '0);
      end else begin
        vbR  = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
        expR = modelVictim(vbR);
        applyStimulus(6'($urandom_range(0, NSET - 1)), '0, vbR,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), expR);
      end
    end

    // Asynchronous reset during MISS_REQ abandons the refill and resets the pointer.
    tick();
    reqValid = 1'b1; reqIdx = 6'd50;
    tick();
    reqValid = 1'b0; tagValid = 1'b1; wayValidBits = 4'b1111;
    tick();
    tagValid = 1'b0;
    #1;
    checkOutput("rstmiss.req", 32'(refillReq), 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("rstmiss.req_drop", 32'(refillReq), 32'd0);
    tick();
    rstn = 1'b1;
    rrModel = 0;
    tick();
    applyStimulus(6'd51, '0, 4'b1111, 0, 0, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
